// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM core and its configuration shadow stage.
// Default values here must match the pwm core's own reset values.
package pwm_pkg;

  localparam int unsigned PWM_W = 32;

  localparam int unsigned PWM_DEF_PERIOD    = 10;
  localparam int unsigned PWM_DEF_DUTY      = 0;
  localparam int unsigned PWM_DEF_DEAD_TIME = 0;
  localparam int unsigned PWM_DT_MAX        = 15;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/pwm_cfg_sat.sv
// Combinational sanitiser for a requested PWM configuration: rejects degenerate
// periods, clamps duty to the period and dead time to DT_MAX.
module pwm_cfg_sat #(
  parameter int unsigned W      = 32,
  parameter int unsigned DT_MAX = 15
) (
  input  logic [W-1:0] req_period,
  input  logic [W-1:0] req_duty,
  input  logic [W-1:0] req_dead_time,
  output logic [W-1:0] sat_duty,
  output logic [W-1:0] sat_dead_time,
  output logic         clamped,
  output logic         reject
);

  logic [W-1:0] dt_lim;
  logic         duty_over;
  logic         dt_over;

  assign dt_lim    = W'(DT_MAX);
  assign duty_over = (req_duty > req_period);
  assign dt_over   = (req_dead_time > dt_lim);

  assign sat_duty      = duty_over ? req_period : req_duty;
  assign sat_dead_time = dt_over ? dt_lim : req_dead_time;
  // A period below 2 cannot produce a meaningful waveform.
  assign reject        = (req_period < W'(2));
  assign clamped       = !reject && (duty_over || dt_over);

endmodule

// File: rtl/pwm_cfg_shadow.sv
// Double-buffered PWM configuration: writes land in a shadow set and are
// committed to the active outputs on period overflow, or at once when disabled.
module pwm_cfg_shadow
  import pwm_pkg::*;
#(
  parameter int unsigned     W             = PWM_W,
  parameter logic [W-1:0]    DEF_PERIOD    = W'(PWM_DEF_PERIOD),
  parameter logic [W-1:0]    DEF_DUTY      = W'(PWM_DEF_DUTY),
  parameter logic [W-1:0]    DEF_DEAD_TIME = W'(PWM_DEF_DEAD_TIME),
  parameter int unsigned     DT_MAX        = PWM_DT_MAX
) (
  input  logic         clk,
  input  logic         reset,
  // Handshake: a write is taken on every rising edge where wr_valid && wr_ready;
  // wr_ready is high whenever reset is released, so one write per cycle is accepted.
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_period,
  input  logic [W-1:0] wr_duty,
  input  logic [W-1:0] wr_dead_time,
  input  logic         pwm_enable,
  input  logic         ovf_trigger,
  output logic [W-1:0] period,
  output logic [W-1:0] duty,
  output logic [W-1:0] dead_time,
  output logic         update_pending,
  output logic         update_done,
  output logic         clamp_evt,
  output logic         wr_err,
  output cfg_state_e   fsm_state
);

  cfg_state_e   state_q, state_d;
  logic         accept;
  logic         load;
  logic         commit;
  logic [W-1:0] sat_duty, sat_dead_time;
  logic         sat_clamped, sat_reject;
  logic [W-1:0] sh_period, sh_duty, sh_dead_time;

  pwm_cfg_sat #(
    .W      (W),
    .DT_MAX (DT_MAX)
  ) u_sat (
    .req_period    (wr_period),
    .req_duty      (wr_duty),
    .req_dead_time (wr_dead_time),
    .sat_duty      (sat_duty),
    .sat_dead_time (sat_dead_time),
    .clamped       (sat_clamped),
    .reject        (sat_reject)
  );

  // Ready depends only on reset, so no write is ever back-pressured.
  assign wr_ready = reset;
  assign accept   = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A write landing in the same cycle as a commit keeps the FSM pending.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    load    = accept && !sat_reject;
    if (state_q == PENDING && (ovf_trigger || !pwm_enable)) begin
      commit  = 1'b1;
      state_d = IDLE;
    end
    if (load) state_d = PENDING;
  end

  assign update_pending = (state_q == PENDING);
  assign fsm_state      = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_period    <= DEF_PERIOD;
      sh_duty      <= DEF_DUTY;
      sh_dead_time <= DEF_DEAD_TIME;
      period       <= DEF_PERIOD;
      duty         <= DEF_DUTY;
      dead_time    <= DEF_DEAD_TIME;
      update_done  <= 1'b0;
      clamp_evt    <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      update_done <= commit;
      clamp_evt   <= accept && sat_clamped;
      wr_err      <= accept && sat_reject;
      if (commit) begin
        period    <= sh_period;
        duty      <= sh_duty;
        dead_time <= sh_dead_time;
      end
      if (load) begin
        sh_period    <= wr_period;
        sh_duty      <= sat_duty;
        sh_dead_time <= sat_dead_time;
      end
    end
  end

endmodule

// File: tb/tb_pwm_cfg_shadow.sv
// Directed self-checking bench for pwm_cfg_shadow.
module tb_pwm_cfg_shadow;
  import pwm_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_period, wr_duty, wr_dead_time;
  logic         pwm_enable;
  logic         ovf_trigger;
  logic [W-1:0] period, duty, dead_time;
  logic         update_pending, update_done, clamp_evt, wr_err;
  cfg_state_e   fsm_state;

  int checks   = 0;
  int failures = 0;
  int done_cnt  = 0;
  int clamp_cnt = 0;
  int err_cnt   = 0;
  logic [W-1:0] exp_q[$];

  pwm_cfg_shadow dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_period      (wr_period),
    .wr_duty        (wr_duty),
    .wr_dead_time   (wr_dead_time),
    .pwm_enable     (pwm_enable),
    .ovf_trigger    (ovf_trigger),
    .period         (period),
    .duty           (duty),
    .dead_time      (dead_time),
    .update_pending (update_pending),
    .update_done    (update_done),
    .clamp_evt      (clamp_evt),
    .wr_err         (wr_err),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every commit must deliver the next expected duty.
  always @(posedge clk) begin
    #1;
    if (update_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_commit", 1, 0);
      else check("commit_duty", duty, exp_q.pop_front());
    end
    if (clamp_evt === 1'b1) clamp_cnt++;
    if (wr_err === 1'b1) err_cnt++;
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [W-1:0] p, input logic [W-1:0] d,
                             input logic [W-1:0] dt, input logic with_ovf);
    @(negedge clk);
    wr_valid     = 1'b1;
    wr_period    = p;
    wr_duty      = d;
    wr_dead_time = dt;
    ovf_trigger  = with_ovf;
    @(posedge clk);
    #1;
    wr_valid    = 1'b0;
    ovf_trigger = 1'b0;
  endtask

  task automatic pulse_ovf();
    @(negedge clk);
    ovf_trigger = 1'b1;
    @(posedge clk);
    #1;
    ovf_trigger = 1'b0;
  endtask

  initial begin
    int d0;
    reset        = 1'b0;
    wr_valid     = 1'b0;
    wr_period    = '0;
    wr_duty      = '0;
    wr_dead_time = '0;
    pwm_enable   = 1'b1;
    ovf_trigger  = 1'b0;

    #3;
    check("ready_in_reset", W'(wr_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_period", period, 10);
    check("rst_duty", duty, 0);
    check("rst_dead_time", dead_time, 0);
    check("rst_pending", W'(update_pending), 0);
    check("rst_state", W'(fsm_state), W'(IDLE));
    check("ready_after_reset", W'(wr_ready), 1);

    repeat (50) tick();
    check("idle_done_cnt", done_cnt, 0);
    check("idle_clamp_cnt", clamp_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);

    // Normal write, waits for overflow
    drive_write(10, 3, 1, 1'b0);
    check("w1_pending", W'(update_pending), 1);
    check("w1_state", W'(fsm_state), W'(PENDING));
    check("w1_clamp", W'(clamp_evt), 0);
    check("w1_duty_held", duty, 0);
    repeat (5) tick();
    check("w1_duty_still_held", duty, 0);
    d0 = done_cnt;
    exp_q.push_back(3);
    pulse_ovf();
    check("w1_duty", duty, 3);
    check("w1_dead_time", dead_time, 1);
    check("w1_done", W'(update_done), 1);
    check("w1_pending_clr", W'(update_pending), 0);
    tick();
    check("w1_done_once", W'(update_done), 0);
    check("w1_done_cnt", done_cnt - d0, 1);

    // Saturation of duty and dead time
    drive_write(10, 500, 40, 1'b0);
    check("w2_clamp", W'(clamp_evt), 1);
    exp_q.push_back(10);
    pulse_ovf();
    check("w2_duty", duty, 10);
    check("w2_dead_time", dead_time, 15);
    check("w2_period", period, 10);

    // Rejected write, and overflow in IDLE does nothing
    d0 = done_cnt;
    drive_write(1, 5, 5, 1'b0);
    check("w3_err", W'(wr_err), 1);
    check("w3_clamp", W'(clamp_evt), 0);
    check("w3_pending", W'(update_pending), 0);
    pulse_ovf();
    check("w3_duty_kept", duty, 10);
    check("w3_period_kept", period, 10);
    check("w3_no_commit", done_cnt - d0, 0);

    // Smallest legal period: duty clamps to 2, dead time exactly at limit
    drive_write(2, 5, 15, 1'b0);
    check("w4_err", W'(wr_err), 0);
    check("w4_clamp", W'(clamp_evt), 1);
    exp_q.push_back(2);
    pulse_ovf();
    check("w4_period", period, 2);
    check("w4_duty", duty, 2);
    check("w4_dead_time", dead_time, 15);

    // Latest write wins
    drive_write(20, 4, 0, 1'b0);
    drive_write(20, 8, 0, 1'b0);
    check("w5_duty_held", duty, 2);
    exp_q.push_back(8);
    pulse_ovf();
    check("w5_duty", duty, 8);
    check("w5_period", period, 20);

    // Write coincident with overflow: old shadow commits, new one stays pending
    drive_write(20, 6, 0, 1'b0);
    exp_q.push_back(6);
    drive_write(20, 9, 0, 1'b1);
    check("w6_duty_old_shadow", duty, 6);
    check("w6_done", W'(update_done), 1);
    check("w6_still_pending", W'(update_pending), 1);
    exp_q.push_back(9);
    pulse_ovf();
    check("w6_duty_new", duty, 9);
    check("w6_pending_clr", W'(update_pending), 0);

    // Core disabled: commit on the following edge
    pwm_enable = 1'b0;
    drive_write(20, 2, 0, 1'b0);
    check("w7_duty_after_1", duty, 9);
    check("w7_pending", W'(update_pending), 1);
    exp_q.push_back(2);
    tick();
    check("w7_duty_after_2", duty, 2);
    check("w7_done", W'(update_done), 1);
    check("w7_pending_clr", W'(update_pending), 0);
    pwm_enable = 1'b1;

    // Reset while pending discards the write
    drive_write(30, 7, 3, 1'b0);
    check("w8_pending", W'(update_pending), 1);
    d0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("w8_rst_period", period, 10);
    check("w8_rst_duty", duty, 0);
    check("w8_rst_dead_time", dead_time, 0);
    check("w8_rst_pending", W'(update_pending), 0);
    check("w8_rst_ready", W'(wr_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    pulse_ovf();
    repeat (3) tick();
    check("w8_duty_default", duty, 0);
    check("w8_period_default", period, 10);
    check("w8_no_commit", done_cnt - d0, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
